// File: rtl/task_ingress_pkg.sv
// rtl/task_ingress_pkg.sv - shared types and constants for the TaskFIFO ingress arbiter
// Purpose: task type encoding, per-tree config entry, task word width helper,
//          and RPU state encodings shared with the dispatcher.
// Ports:   none (package)
package task_ingress_pkg;

    localparam logic TASK_PUSH = 1'b1;
    localparam logic TASK_POP  = 1'b0;

    // Wide enough for any level count the subsystem is built with.
    localparam int CFG_LEVEL_BITS = 4;

    typedef struct packed {
        logic                      en;
        logic [CFG_LEVEL_BITS-1:0] level;
    } cfg_entry_t;

    // Default task word: {type, treeId, data}.
    localparam int DEF_PTW           = 16;
    localparam int DEF_TREE_NUM_BITS = 2;
    localparam int TASK_WORD_W       = DEF_PTW + DEF_TREE_NUM_BITS + 1;

    function automatic int task_word_bits(input int ptw, input int tree_bits);
        return ptw + tree_bits + 1;
    endfunction

    typedef enum logic [1:0] {
        RPU_IDLE    = 2'd0,
        RPU_PUSH    = 2'd1,
        RPU_POP     = 2'd2,
        RPU_REPLACE = 2'd3
    } rpu_state_t;

endpackage

// File: rtl/task_ingress_arbiter_rr_arbiter.sv
// rtl/task_ingress_arbiter_rr_arbiter.sv - combinational round-robin pointer search
// Purpose: grant the first requester at or after ptr, wrapping modulo N.
// Ports:   req   - request vector
//          ptr   - search start position
//          grant - one-hot grant
//          any   - some request granted
//          idx   - index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int NB = 2
) (
    input  logic [N-1:0]  req,
    input  logic [NB-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any,
    output logic [NB-1:0] idx
);

    logic [NB-1:0] cand;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = NB'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                any         = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/task_ingress_arbiter.sv
// rtl/task_ingress_arbiter.sv - per-level round-robin ingress into the BMW TaskFIFOs
// Purpose: maps tenant trees to root levels, arbitrates one task per level per
//          cycle, tracks per-tree occupancy and drops empty pops / full pushes.
// Ports:   i_clk, i_arst_n            - clock, async active-low reset
//          i_req_valid/type/data      - per-tree push/pop requests
//          o_req_ready                - request consumed (combinational)
//          o_req_drop                 - consumed request was rejected (registered)
//          i_cfg_we/tree/level/en     - config table write
//          o_cfg_err                  - config write refused (registered)
//          o_push_TaskFIFO, o_TaskFIFO_data - registered TaskFIFO write per level
//          i_TaskFIFO_full/afull      - TaskFIFO backpressure per level
//          o_tree_count               - per-tree occupancy
module task_ingress_arbiter
    import task_ingress_pkg::*;
#(
    parameter int PTW           = 16,
    parameter int LEVEL         = 4,
    parameter int TREE_NUM      = 4,
    parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
    parameter int LEVEL_BITS    = $clog2(LEVEL),
    parameter int CAP_BITS      = 8,
    parameter int TREE_CAP      = 2**CAP_BITS-1
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic [TREE_NUM-1:0]        i_req_valid,
    input  logic [TREE_NUM-1:0]        i_req_type,
    input  logic [PTW-1:0]             i_req_data [0:TREE_NUM-1],
    output logic [TREE_NUM-1:0]        o_req_ready,
    output logic [TREE_NUM-1:0]        o_req_drop,
    input  logic                       i_cfg_we,
    input  logic [TREE_NUM_BITS-1:0]   i_cfg_tree,
    input  logic [LEVEL_BITS-1:0]      i_cfg_level,
    input  logic                       i_cfg_en,
    output logic                       o_cfg_err,
    output logic [LEVEL-1:0]           o_push_TaskFIFO,
    output logic [PTW+TREE_NUM_BITS:0] o_TaskFIFO_data [0:LEVEL-1],
    input  logic [LEVEL-1:0]           i_TaskFIFO_full,
    input  logic [LEVEL-1:0]           i_TaskFIFO_afull,
    output logic [CAP_BITS-1:0]        o_tree_count [0:TREE_NUM-1]
);

    localparam int TW = task_word_bits(PTW, TREE_NUM_BITS);
    localparam logic [CAP_BITS-1:0] CAP_MAX = CAP_BITS'(TREE_CAP);

    cfg_entry_t                 cfg_q   [TREE_NUM];
    logic [CAP_BITS-1:0]        count_q [TREE_NUM];
    logic [TREE_NUM_BITS-1:0]   ptr_q   [LEVEL];
    logic [LEVEL-1:0]           push_q;
    logic [TW-1:0]              data_q  [LEVEL];
    logic [TREE_NUM-1:0]        drop_q;
    logic                       err_q;

    logic [TREE_NUM-1:0]        elig    [LEVEL];
    logic [TREE_NUM-1:0]        grant   [LEVEL];
    logic [LEVEL-1:0]           gany;
    logic [TREE_NUM_BITS-1:0]   gidx    [LEVEL];
    logic [TREE_NUM-1:0]        ready;
    logic [TREE_NUM-1:0]        accept;
    logic [LEVEL-1:0]           wr;
    logic [TW-1:0]              word    [LEVEL];
    logic                       cfg_ok;

    // A level whose FIFO is almost full cannot take a new word while the
    // registered write from last cycle is still landing in it.
    always_comb begin
        for (int l = 0; l < LEVEL; l++) begin
            elig[l] = '0;
            for (int t = 0; t < TREE_NUM; t++) begin
                elig[l][t] = i_req_valid[t] && cfg_q[t].en
                          && (cfg_q[t].level == CFG_LEVEL_BITS'(l))
                          && !i_TaskFIFO_full[l]
                          && !(i_TaskFIFO_afull[l] && push_q[l]);
            end
        end
    end

    for (genvar l = 0; l < LEVEL; l++) begin : g_arb
        rr_arbiter #(
            .N  (TREE_NUM),
            .NB (TREE_NUM_BITS)
        ) u_arb (
            .req   (elig[l]),
            .ptr   (ptr_q[l]),
            .grant (grant[l]),
            .any   (gany[l]),
            .idx   (gidx[l])
        );
    end

    // Each tree maps to exactly one level, so OR-ing grants never collides.
    always_comb begin
        ready = '0;
        for (int l = 0; l < LEVEL; l++) begin
            ready = ready | grant[l];
        end
    end

    always_comb begin
        accept = '0;
        for (int t = 0; t < TREE_NUM; t++) begin
            accept[t] = (i_req_type[t] == TASK_PUSH) ? (count_q[t] != CAP_MAX)
                                                     : (count_q[t] != '0);
        end
    end

    always_comb begin
        for (int l = 0; l < LEVEL; l++) begin
            wr[l]   = gany[l] && accept[gidx[l]];
            word[l] = {i_req_type[gidx[l]], gidx[l],
                       (i_req_type[gidx[l]] == TASK_PUSH) ? i_req_data[gidx[l]]
                                                          : {PTW{1'b0}}};
        end
    end

    // Remapping a tree with live elements or a request in flight would strand
    // tasks on the old level.
    assign cfg_ok = i_cfg_we && (count_q[i_cfg_tree] == '0) && !ready[i_cfg_tree];

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            push_q <= '0;
            drop_q <= '0;
            err_q  <= 1'b0;
            for (int l = 0; l < LEVEL; l++) begin
                data_q[l] <= '0;
                ptr_q[l]  <= '0;
            end
            for (int t = 0; t < TREE_NUM; t++) begin
                count_q[t] <= '0;
                cfg_q[t]   <= '0;
            end
        end else begin
            push_q <= wr;
            for (int l = 0; l < LEVEL; l++) begin
                if (wr[l]) begin
                    data_q[l] <= word[l];
                end
                if (gany[l]) begin
                    ptr_q[l] <= (gidx[l] == TREE_NUM_BITS'(TREE_NUM-1)) ? '0
                                                                        : gidx[l] + 1'b1;
                end
            end
            for (int t = 0; t < TREE_NUM; t++) begin
                drop_q[t] <= ready[t] && !accept[t];
                if (ready[t] && accept[t]) begin
                    count_q[t] <= (i_req_type[t] == TASK_PUSH) ? count_q[t] + 1'b1
                                                               : count_q[t] - 1'b1;
                end
            end
            err_q <= i_cfg_we && !cfg_ok;
            if (cfg_ok) begin
                cfg_q[i_cfg_tree] <= '{en: i_cfg_en, level: CFG_LEVEL_BITS'(i_cfg_level)};
            end
        end
    end

    assign o_req_ready     = ready;
    assign o_req_drop      = drop_q;
    assign o_cfg_err       = err_q;
    assign o_push_TaskFIFO = push_q;
    assign o_TaskFIFO_data = data_q;
    assign o_tree_count    = count_q;

endmodule

// File: tb/tb_task_ingress_arbiter.sv
// tb/tb_task_ingress_arbiter.sv - directed self-checking bench for task_ingress_arbiter
module tb_task_ingress_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_type;
    logic [15:0] req_data [0:3];
    logic [3:0]  req_ready;
    logic [3:0]  req_drop;
    logic        cfg_we;
    logic [1:0]  cfg_tree;
    logic [1:0]  cfg_level;
    logic        cfg_en;
    logic        cfg_err;
    logic [3:0]  push;
    logic [18:0] fifo_data [0:3];
    logic [3:0]  fifo_full;
    logic [3:0]  fifo_afull;
    logic [7:0]  tree_count [0:3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task_ingress_arbiter dut (
        .i_clk            (clk),
        .i_arst_n         (rst_n),
        .i_req_valid      (req_valid),
        .i_req_type       (req_type),
        .i_req_data       (req_data),
        .o_req_ready      (req_ready),
        .o_req_drop       (req_drop),
        .i_cfg_we         (cfg_we),
        .i_cfg_tree       (cfg_tree),
        .i_cfg_level      (cfg_level),
        .i_cfg_en         (cfg_en),
        .o_cfg_err        (cfg_err),
        .o_push_TaskFIFO  (push),
        .o_TaskFIFO_data  (fifo_data),
        .i_TaskFIFO_full  (fifo_full),
        .i_TaskFIFO_afull (fifo_afull),
        .o_tree_count     (tree_count)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int t, input int lvl, input logic en, input logic exp_err);
        cfg_we    = 1'b1;
        cfg_tree  = 2'(t);
        cfg_level = 2'(lvl);
        cfg_en    = en;
        tick();
        cfg_we = 1'b0;
        check_vec("cfg_err", 32'(cfg_err), 32'(exp_err));
    endtask

    int rr_seq [6] = '{0, 2, 3, 0, 2, 3};

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_type   = '0;
        for (int t = 0; t < 4; t++) req_data[t] = '0;
        cfg_we     = 1'b0;
        cfg_tree   = '0;
        cfg_level  = '0;
        cfg_en     = 1'b0;
        fifo_full  = '0;
        fifo_afull = '0;
        #2;
        check_vec("rst_ready", 32'(req_ready), 32'h0);
        check_vec("rst_push", 32'(push), 32'h0);
        check_vec("rst_drop", 32'(req_drop), 32'h0);
        check_vec("rst_cfg_err", 32'(cfg_err), 32'h0);
        check_vec("rst_data0", 32'(fifo_data[0]), 32'h0);
        check_vec("rst_count0", 32'(tree_count[0]), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // basic push: tree 1 on level 2
        cfg_write(1, 2, 1'b1, 1'b0);
        req_valid   = 4'b0010;
        req_type    = 4'b0010;
        req_data[1] = 16'h00AB;
        #1;
        check_vec("basic_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        check_vec("basic_push", 32'(push), 32'h4);
        check_vec("basic_data", 32'(fifo_data[2]), 32'h500AB);
        check_vec("basic_count", 32'(tree_count[1]), 32'h1);
        check_vec("basic_drop", 32'(req_drop), 32'h0);

        // round robin: trees 0,2,3 on level 0
        cfg_write(0, 0, 1'b1, 1'b0);
        cfg_write(2, 0, 1'b1, 1'b0);
        cfg_write(3, 0, 1'b1, 1'b0);
        req_valid   = 4'b1101;
        req_type    = 4'b1101;
        req_data[0] = 16'h1000;
        req_data[2] = 16'h1002;
        req_data[3] = 16'h1003;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_vec("rr_ready", 32'(req_ready), 32'(1) << rr_seq[i]);
            tick();
            check_vec("rr_push", 32'(push), 32'h1);
            check_vec("rr_data", 32'(fifo_data[0]),
                      (32'h1 << 18) | (32'(rr_seq[i]) << 16) | (32'h1000 + 32'(rr_seq[i])));
        end
        req_valid = '0;
        check_vec("rr_count0", 32'(tree_count[0]), 32'h2);
        check_vec("rr_count2", 32'(tree_count[2]), 32'h2);
        check_vec("rr_count3", 32'(tree_count[3]), 32'h2);

        // drain tree 0, then pop on empty
        req_valid = 4'b0001;
        req_type  = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_vec("pop_ready", 32'(req_ready), 32'h1);
            tick();
            check_vec("pop_push", 32'(push), 32'h1);
            check_vec("pop_data", 32'(fifo_data[0]), 32'h0);
        end
        #1;
        check_vec("empty_ready", 32'(req_ready), 32'h1);
        tick();
        check_vec("empty_drop", 32'(req_drop), 32'h1);
        check_vec("empty_push", 32'(push), 32'h0);
        check_vec("empty_count", 32'(tree_count[0]), 32'h0);

        // fill tree 0 to capacity, then one more push
        req_type    = 4'b0001;
        req_data[0] = 16'h55AA;
        repeat (255) tick();
        check_vec("full_count", 32'(tree_count[0]), 32'd255);
        check_vec("full_ready", 32'(req_ready), 32'h1);
        tick();
        check_vec("full_drop", 32'(req_drop), 32'h1);
        check_vec("full_push", 32'(push), 32'h0);
        check_vec("full_count_hold", 32'(tree_count[0]), 32'd255);
        req_valid = '0;
        tick();
        check_vec("drop_pulse", 32'(req_drop), 32'h0);

        // config guard on tree 2
        req_valid   = 4'b0100;
        req_type    = 4'b0100;
        req_data[2] = 16'h2222;
        tick();
        req_valid = '0;
        check_vec("guard_count", 32'(tree_count[2]), 32'h3);
        cfg_write(2, 1, 1'b1, 1'b1);
        req_valid = 4'b0100;
        req_type  = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_vec("guard_pop_ready", 32'(req_ready), 32'h4);
            tick();
            check_vec("guard_old_level", 32'(push), 32'h1);
            check_vec("guard_pop_data", 32'(fifo_data[0]), 32'h20000);
        end
        req_valid = '0;
        check_vec("guard_drained", 32'(tree_count[2]), 32'h0);
        cfg_write(2, 1, 1'b1, 1'b0);

        // backpressure on level 1
        req_valid   = 4'b0100;
        req_type    = 4'b0100;
        req_data[2] = 16'h7777;
        #1;
        check_vec("bp_ready", 32'(req_ready), 32'h4);
        tick();
        check_vec("bp_push", 32'(push), 32'h2);
        fifo_afull = 4'b0010;
        #1;
        check_vec("afull_pending", 32'(req_ready), 32'h0);
        tick();
        check_vec("afull_no_push", 32'(push), 32'h0);
        check_vec("afull_idle", 32'(req_ready), 32'h4);
        tick();
        check_vec("afull_push", 32'(push), 32'h2);
        fifo_afull = '0;
        fifo_full  = 4'b0010;
        #1;
        check_vec("full_stall", 32'(req_ready), 32'h0);
        tick();
        check_vec("full_hold", 32'(req_ready), 32'h0);
        check_vec("full_no_push", 32'(push), 32'h0);
        fifo_full = '0;
        #1;
        check_vec("full_release", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;

        // reset in the middle of traffic
        req_valid   = 4'b0010;
        req_type    = 4'b0010;
        req_data[1] = 16'h1111;
        tick();
        check_vec("mid_push", 32'(push), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("arst_push", 32'(push), 32'h0);
        check_vec("arst_ready", 32'(req_ready), 32'h0);
        check_vec("arst_count1", 32'(tree_count[1]), 32'h0);
        check_vec("arst_data2", 32'(fifo_data[2]), 32'h0);
        check_vec("arst_drop", 32'(req_drop), 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        check_vec("post_rst_ready", 32'(req_ready), 32'h0);
        tick();
        check_vec("post_rst_push", 32'(push), 32'h0);
        cfg_write(1, 2, 1'b1, 1'b0);
        #1;
        check_vec("reen_ready", 32'(req_ready), 32'h2);
        tick();
        check_vec("reen_push", 32'(push), 32'h4);
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/task_ingress_arbiter.md
# task_ingress_arbiter

Front-end scheduler for the per-level TaskFIFOs of the BMW PIFO subsystem. It accepts push and pop requests from `TREE_NUM` tenant ports and maps each tree to its configured root level. Per level, it round-robin arbitrates among the trees mapped there and writes one task word per level per cycle into that level's TaskFIFO. It keeps a per-tree occupancy count so that pops on an empty tree and pushes on a full tree are dropped rather than forwarded.

## Interface
- `PTW`, 16, push payload width
- `LEVEL`, 4, number of levels/TaskFIFOs
- `TREE_NUM`, 4, number of virtual trees
- `TREE_NUM_BITS`, `$clog2(TREE_NUM)`, tree id width
- `LEVEL_BITS`, `$clog2(LEVEL)`, level index width
- `CAP_BITS`, 8, occupancy counter width
- `TREE_CAP`, `2**CAP_BITS-1`, max elements per tree
- `i_clk`  in  1  clock; single clock domain
- `i_arst_n`  in  1  reset, asynchronous, active-low
- `i_req_valid`  in  `[TREE_NUM-1:0]`  request per tree
- `i_req_type`  in  `[TREE_NUM-1:0]`  1 = push, 0 = pop
- `i_req_data`  in  `[PTW-1:0] [0:TREE_NUM-1]`  push payload
- `o_req_ready`  out  `[TREE_NUM-1:0]`  request consumed this cycle (combinational)
- `o_req_drop`  out  `[TREE_NUM-1:0]`  registered pulse: consumed request was rejected
- `i_cfg_we`  in  1  config write strobe
- `i_cfg_tree`  in  `TREE_NUM_BITS`  tree being configured
- `i_cfg_level`  in  `LEVEL_BITS`  root level for that tree
- `i_cfg_en`  in  1  tree enable
- `o_cfg_err`  out  1  registered pulse: config write refused
- `o_push_TaskFIFO`  out  `[LEVEL-1:0]`  TaskFIFO write strobe
- `o_TaskFIFO_data`  out  `[PTW+TREE_NUM_BITS:0] [0:LEVEL-1]`  task word `{type, treeId, data}`
- `i_TaskFIFO_full`  in  `[LEVEL-1:0]`  FIFO full
- `i_TaskFIFO_afull`  in  `[LEVEL-1:0]`  one or fewer free entries
- `o_tree_count`  out  `[CAP_BITS-1:0] [0:TREE_NUM-1]`  occupancy per tree

## Operation
- **Config table.** Each tree has an entry `{en, level}`. Reset value is `en=0`, `level=0`.
- **Eligibility.** Tree t is eligible for level L when all of the following hold:
  - `i_req_valid[t]` is high;
  - `en[t]` is set and `level[t] == L`;
  - `!i_TaskFIFO_full[L]`;
  - NOT (`i_TaskFIFO_afull[L]` and `o_push_TaskFIFO[L]`). This covers the in-flight registered write.
- **Arbitration.** Each level has a round-robin pointer `ptr[L]`, reset to 0.
  - The search starts at `ptr[L]` and wraps modulo `TREE_NUM`; the first eligible tree is granted.
  - On a grant to t, `ptr[L] <= (t+1) % TREE_NUM`. With no grant, the pointer holds.
- **Ready.** `o_req_ready[t]` = granted. At most one grant per level per cycle; levels arbitrate independently.
- **Granted push.**
  - If `count[t] < TREE_CAP`: write `{1, t, data}` and increment `count[t]`.
  - Otherwise: drop it.
- **Granted pop.**
  - If `count[t] > 0`: write `{1'b0, t, '0}` and decrement `count[t]`.
  - Otherwise: drop it.
- **Drops.** A drop consumes the request (ready high), produces no FIFO write, and pulses `o_req_drop[t]`. Drops still require FIFO eligibility.
- **Disabled trees.** Ready is held 0 and requests stall.
- **Config write.**
  - Accepted only if `count[i_cfg_tree] == 0` and that tree is not granted in the same cycle.
  - Otherwise the table is unchanged and `o_cfg_err` pulses.
  - A grant in the same cycle uses the old mapping.
- **Counter range.** Counters never wrap: boundary requests are dropped at 0 and at `TREE_CAP`.

## Timing
- **Grant.** Cycle N: `o_req_ready` is high combinationally.
- **Visible results at N+1.** After the edge ending cycle N, the following are visible in cycle N+1:
  - `o_push_TaskFIFO`, `o_TaskFIFO_data`, `o_req_drop`, `o_cfg_err`;
  - updated `count` and `ptr`.
- **Latency.** Request to FIFO write is 1 cycle.
- **Throughput.** Back-to-back grants to the same tree are allowed. Each decision uses the counter value already updated by the previous grant.
- **Reset.** All outputs are 0, counts are 0, pointers are 0, and the table is disabled, immediately on `i_arst_n` low. In-flight registered writes are discarded.
- **Data stability.** `o_TaskFIFO_data` is don't-care when its strobe is low; it is held 0 after reset until the first write.

## Structure
- **Package `task_ingress_pkg`:**
  - task type encoding (`TASK_PUSH=1`, `TASK_POP=0`);
  - `cfg_entry_t` struct `{en, level}`;
  - task-word width localparam `PTW+TREE_NUM_BITS+1`;
  - RPU state encodings shared with the dispatcher.
- **Sub-module `rr_arbiter`:**
  - `TREE_NUM`-wide request vector and pointer in, one-hot grant out;
  - purely combinational pointer search;
  - instantiated once per level.
- **Top level holds:** config table, counters, pointers and the output register stage.

## Test plan
- **Basic push.** Tree 1 cfg `{en=1, level=2}`, push 0x00AB.
  - `o_req_ready[1]` in the same cycle.
  - Next cycle: `o_push_TaskFIFO=4'b0100`, data `{1, 2'd1, 16'h00AB}`, `count[1]=1`.
- **Round robin.** Trees 0, 2, 3 all mapped to level 0, continuous pushes, FIFO never full → grants cycle 0, 2, 3, 0, 2, 3; one write per cycle.
- **Empty pop and full push.**
  - Pop on tree 0 with `count=0` → ready, `o_req_drop[0]` next cycle, no write, count stays 0.
  - Push with `count=255` → drop, count stays 255.
- **FIFO backpressure.** Hold `afull[1]=1` while a write is pending → no grant on level 1 that cycle. `full[1]=1` → ready stays 0 until it deasserts.
- **Config guard.**
  - Cfg write to tree 2 while `count[2]=3` → `o_cfg_err` pulse, mapping unchanged.
  - After 3 pops → write accepted, `o_cfg_err=0`.
- **Reset mid-stream.** Assert `i_arst_n=0` during continuous traffic → all outputs 0 asynchronously. After release, a request from previously enabled tree 1 is not granted until it is reconfigured.
